// File: rtl/eth_rx_mac.sv
// rtl/eth_rx_mac.sv - byte-wide Ethernet receive MAC: preamble strip, FCS check, payload stream
module eth_rx_mac #(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        clk_125,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        m_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    localparam logic [10:0] MAX_CNT  = 11'(MAX_LEN);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_LEN);
    localparam logic [31:0] CRC_GOOD = 32'hDEBB20E3;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  pend_q, pend_d;
    logic        err_q, err_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        m_err_q, m_err_d;
    logic [15:0] frames_ok_q, frames_ok_d;
    logic [15:0] frames_bad_q, frames_bad_d;
    logic        ok_inc, bad_inc, final_err;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Next-state, datapath and beat generation. The 4-byte hold register delays
    // the stream so the FCS never reaches the output; pending is occupied once
    // five or more bytes have been seen, so the count alone tracks occupancy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        err_d     = err_q;
        m_data_d  = m_data_q;
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_err_d   = 1'b0;
        ok_inc    = 1'b0;
        bad_inc   = 1'b0;
        final_err = (crc_q != CRC_GOOD) || err_q || (cnt_q < MIN_CNT);
        case (state_q)
            IDLE: begin
                if (rx_dv) begin
                    if (rx_data == 8'h55) begin
                        state_d = PREAMBLE;
                    end else begin
                        state_d = DROP;
                        bad_inc = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_dv || rx_er) begin
                    state_d = DROP;
                    bad_inc = 1'b1;
                end else if (rx_data == 8'hD5) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    crc_d   = '1;
                    hold_d  = '0;
                    err_d   = 1'b0;
                end else if (rx_data != 8'h55) begin
                    state_d = DROP;
                    bad_inc = 1'b1;
                end
            end
            DATA: begin
                if (rx_dv) begin
                    if (cnt_q >= MAX_CNT) begin
                        // Oversize: close the frame as bad and discard the rest.
                        m_data_d  = pend_q;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_err_d   = 1'b1;
                        bad_inc   = 1'b1;
                        state_d   = DROP;
                    end else begin
                        cnt_d  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                        crc_d  = crc_byte(crc_q, rx_data);
                        hold_d = {hold_q[23:0], rx_data};
                        if (rx_er) err_d = 1'b1;
                        if (cnt_q >= 11'd4) pend_d = hold_q[31:24];
                        if (cnt_q >= 11'd5) begin
                            m_data_d  = pend_q;
                            m_valid_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q <= 11'd4) begin
                        bad_inc = 1'b1;
                    end else begin
                        m_data_d  = pend_q;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_err_d   = final_err;
                        ok_inc    = !final_err;
                        bad_inc   = final_err;
                    end
                end
            end
            default: begin
                if (!rx_dv) state_d = IDLE;
            end
        endcase
        frames_ok_d  = (ok_inc && frames_ok_q != 16'hFFFF) ? frames_ok_q + 16'd1 : frames_ok_q;
        frames_bad_d = (bad_inc && frames_bad_q != 16'hFFFF) ? frames_bad_q + 16'd1 : frames_bad_q;
    end

    // State and output registers; reset lands in DROP so a frame in flight is discarded.
    always_ff @(posedge clk_125 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= DROP;
            cnt_q        <= '0;
            crc_q        <= '0;
            hold_q       <= '0;
            pend_q       <= '0;
            err_q        <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            m_last_q     <= 1'b0;
            m_err_q      <= 1'b0;
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            hold_q       <= hold_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            m_last_q     <= m_last_d;
            m_err_q      <= m_err_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign m_err      = m_err_q;
    assign frames_ok  = frames_ok_q;
    assign frames_bad = frames_bad_q;

endmodule

// File: tb/tb_eth_rx_mac.sv
// tb/tb_eth_rx_mac.sv - scoreboard bench for eth_rx_mac with a frame-level reference model
module tb_eth_rx_mac;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    typedef logic [7:0] bq_t[$];
    typedef bit eq_t[$];
    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       err;
    } beat_t;

    logic        clk_125 = 1'b0;
    logic        rst_n   = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_dv   = 1'b0;
    logic        rx_er   = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid, m_last, m_err;
    logic [15:0] frames_ok, frames_bad;

    int    total  = 0;
    int    passed = 0;
    beat_t exp_q[$];
    int    exp_ok  = 0;
    int    exp_bad = 0;

    eth_rx_mac #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .clk_125   (clk_125),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_dv     (rx_dv),
        .rx_er     (rx_er),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_err     (m_err),
        .frames_ok (frames_ok),
        .frames_bad(frames_bad)
    );

    always #4 clk_125 = ~clk_125;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Monitor: every beat must match the head of the expected queue.
    always @(negedge clk_125) begin
        beat_t e;
        if (rst_n && m_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_beat", {m_data, m_last, m_err}, 0);
            end else begin
                e = exp_q.pop_front();
                chk({m_data, m_last, m_err} == e, "beat", {m_data, m_last, m_err}, e);
            end
        end
    end

    // Standard Ethernet FCS value of a byte sequence.
    function automatic logic [31:0] fcs_of(input bq_t b, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t with_fcs(input bq_t p);
        bq_t b = p;
        logic [31:0] f = fcs_of(p, p.size());
        for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
        return b;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t b;
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
        return b;
    endfunction

    function automatic bq_t good_pre();
        bq_t p;
        for (int i = 0; i < 7; i++) p.push_back(8'h55);
        p.push_back(8'hD5);
        return p;
    endfunction

    function automatic eq_t no_er(input int n);
        eq_t e;
        for (int i = 0; i < n; i++) e.push_back(1'b0);
        return e;
    endfunction

    // Reference model of one frame: what beats come out and which counter moves.
    task automatic model_frame(input bq_t pre, input bq_t body, input eq_t er);
        int    n = body.size();
        int    nb;
        bit    in_data = 1'b0;
        bit    er_any = 1'b0;
        bit    bad;
        logic [31:0] fcs_rx;
        beat_t b;
        if (pre[0] == 8'h55) begin
            for (int i = 1; i < pre.size(); i++) begin
                if (pre[i] == 8'hD5) begin in_data = 1'b1; break; end
                if (pre[i] != 8'h55) break;
            end
        end
        if (!in_data || n <= 4) begin
            exp_bad++;
            return;
        end
        if (n > MAX_LEN) begin
            nb  = MAX_LEN - 4;
            bad = 1'b1;
        end else begin
            nb = n - 4;
            for (int i = 0; i < n; i++) er_any |= er[i];
            fcs_rx = {body[n-1], body[n-2], body[n-3], body[n-4]};
            bad = (fcs_rx != fcs_of(body, nb)) || er_any || (n < MIN_LEN);
        end
        for (int i = 0; i < nb; i++) begin
            b.d    = body[i];
            b.last = (i == nb - 1);
            b.err  = (i == nb - 1) && bad;
            exp_q.push_back(b);
        end
        if (bad) exp_bad++;
        else exp_ok++;
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        rx_data = d;
        rx_dv   = dv;
        rx_er   = er;
        @(posedge clk_125);
        #1;
    endtask

    task automatic send_frame(input bq_t pre, input bq_t body, input eq_t er);
        model_frame(pre, body, er);
        foreach (pre[i]) drive(pre[i], 1'b1, 1'b0);
        foreach (body[i]) drive(body[i], 1'b1, er[i]);
        repeat (12) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic check_counts(input string name);
        chk(exp_q.size() == 0, {name, "_missing_beats"}, exp_q.size(), 0);
        chk(frames_ok == 16'(exp_ok), {name, "_frames_ok"}, frames_ok, exp_ok);
        chk(frames_bad == 16'(exp_bad), {name, "_frames_bad"}, frames_bad, exp_bad);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({m_valid, m_last, m_err} == 3'b000, {name, "_flags"}, {m_valid, m_last, m_err}, 0);
        chk(m_data == 8'h00, {name, "_m_data"}, m_data, 0);
        chk(frames_ok == 16'h0 && frames_bad == 16'h0, {name, "_counters"},
            {frames_ok, frames_bad}, 0);
    endtask

    initial begin
        #(8 * 60000);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        bq_t pay, body, pre;
        eq_t er;
        int  idx;

        repeat (3) @(negedge clk_125);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        repeat (3) drive(8'h00, 1'b0, 1'b0);

        // Nominal 60-byte payload.
        pay  = rand_bytes(60);
        body = with_fcs(pay);
        send_frame(good_pre(), body, no_er(64));
        check_counts("good60");
        chk(frames_ok == 16'd1, "good60_ok_is_1", frames_ok, 1);

        // Corrupted payload byte 10.
        body[10] = body[10] ^ 8'h01;
        send_frame(good_pre(), body, no_er(64));
        check_counts("crc_bad");

        // rx_er for one cycle at payload byte 20.
        body = with_fcs(rand_bytes(60));
        er = no_er(64);
        er[20] = 1'b1;
        send_frame(good_pre(), body, er);
        check_counts("rx_er");

        // Bad SFD, then a good frame.
        pre = good_pre();
        pre[7] = 8'h5D;
        send_frame(pre, rand_bytes(40), no_er(40));
        check_counts("bad_sfd");
        send_frame(good_pre(), with_fcs(rand_bytes(60)), no_er(64));
        check_counts("after_bad_sfd");

        // Length boundaries: 4, 5, 63, 64, MAX_LEN, MAX_LEN+1 and 1600 bytes after SFD.
        send_frame(good_pre(), with_fcs(rand_bytes(0)), no_er(4));
        check_counts("len4");
        send_frame(good_pre(), with_fcs(rand_bytes(1)), no_er(5));
        check_counts("len5");
        send_frame(good_pre(), with_fcs(rand_bytes(59)), no_er(63));
        check_counts("len63");
        send_frame(good_pre(), with_fcs(rand_bytes(60)), no_er(64));
        check_counts("len64");
        send_frame(good_pre(), with_fcs(rand_bytes(MAX_LEN - 4)), no_er(MAX_LEN));
        check_counts("len_max");
        send_frame(good_pre(), with_fcs(rand_bytes(MAX_LEN - 3)), no_er(MAX_LEN + 1));
        check_counts("len_max_plus1");
        send_frame(good_pre(), rand_bytes(1600), no_er(1600));
        check_counts("len1600");

        // Reset in the middle of a frame with rx_dv held high.
        body = with_fcs(rand_bytes(66));
        pre  = good_pre();
        for (int i = 0; i < 25; i++) exp_q.push_back('{d: body[i], last: 1'b0, err: 1'b0});
        foreach (pre[i]) drive(pre[i], 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) drive(body[i], 1'b1, 1'b0);
        @(negedge clk_125);
        #1 rst_n = 1'b0;
        exp_ok  = 0;
        exp_bad = 0;
        repeat (2) @(negedge clk_125);
        check_reset_outputs("mid_reset");
        #1 rst_n = 1'b1;
        @(posedge clk_125);
        #1;
        for (int i = 30; i < 70; i++) drive(body[i], 1'b1, 1'b0);
        repeat (12) drive(8'h00, 1'b0, 1'b0);
        check_counts("after_reset");
        send_frame(good_pre(), with_fcs(rand_bytes(60)), no_er(64));
        check_counts("post_reset_good");

        // Randomized frames.
        for (int t = 0; t < 20; t++) begin
            pre = good_pre();
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, 7);
                pre[idx] = 8'h3C;
            end
            if ($urandom_range(0, 7) == 0) body = rand_bytes($urandom_range(0, 3));
            else body = with_fcs(rand_bytes($urandom_range(0, 80)));
            er = no_er(body.size());
            if (body.size() > 0 && $urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, body.size() - 1);
                body[idx] = body[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            if (body.size() > 0 && $urandom_range(0, 4) == 0) er[$urandom_range(0, body.size() - 1)] = 1'b1;
            send_frame(pre, body, er);
            check_counts("random");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
